// File: rtl/pm_cpu_pkg.sv
// Shared S1C88 CPU types: fetch FSM states, immediate-size codes
// and the instruction bundle handed from fetch to execute.
package pm_cpu_pkg;

    localparam logic IMM_SIZE_8    = 1'b0;
    localparam logic IMM_SIZE_16   = 1'b1;
    localparam int   MAX_INSTR_LEN = 4;

    typedef logic [$clog2(MAX_INSTR_LEN+1)-1:0] len_t;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_FETCH_OP,
        FS_DISPATCH,
        FS_FETCH_EXT,
        FS_FETCH_IMM_LO,
        FS_FETCH_IMM_HI,
        FS_VALID
    } fetch_state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  opext;
        logic [15:0] imm;
        logic [15:0] pc;
        len_t        len;
    } fetch_instr_t;

endpackage

// File: rtl/instr_fetch.sv
// Byte-serial S1C88 instruction fetch sequencer feeding the opcode decoder.
// Define FETCH_PREFETCH_EN to prefetch the next opcode while execute stalls.
module instr_fetch
    import pm_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data,
    output logic [7:0]            dec_opcode,
    output logic [7:0]            dec_opext,
    input  logic                  dec_need_opext,
    input  logic                  dec_need_imm,
    input  logic                  dec_imm_size,
    input  logic                  redirect,
    input  logic [15:0]           redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            instr_opcode,
    output logic [7:0]            instr_opext,
    output logic [15:0]           instr_imm,
    output logic [15:0]           instr_pc,
    output logic [2:0]            instr_len
);

`ifdef FETCH_PREFETCH_EN
    localparam logic VALID_REQ = 1'b1;
`else
    localparam logic VALID_REQ = 1'b0;
`endif

    fetch_state_t state;
    fetch_instr_t ins;
    logic [15:0]  pc;
    logic         req_q;
    logic         valid_q;
    logic         ext_done;
    logic         redir_pend;
    logic [15:0]  redir_pc;
    logic [15:0]  pc_inc;
    logic [15:0]  tgt;

    assign pc_inc = pc + 16'd1;
    // A redirect in the ack cycle beats one parked earlier.
    assign tgt    = redirect ? redirect_pc : redir_pc;

`ifdef FETCH_PREFETCH_EN
    logic [7:0] pf_buf;
    logic       pf_valid;
    logic       outstanding;

    assign outstanding = req_q && !mem_ack;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FS_IDLE;
            ins        <= '0;
            pc         <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            ext_done   <= 1'b0;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
`ifdef FETCH_PREFETCH_EN
            pf_buf     <= '0;
            pf_valid   <= 1'b0;
`endif
        end else begin
            unique case (state)
                FS_IDLE: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        req_q <= 1'b1;
                        state <= FS_FETCH_OP;
                    end
                end

                FS_FETCH_OP, FS_FETCH_EXT,
                FS_FETCH_IMM_LO, FS_FETCH_IMM_HI: begin
                    if (mem_ack && (redirect || redir_pend)) begin
                        pc         <= tgt;
                        redir_pend <= 1'b0;
                        state      <= FS_FETCH_OP;
                    end else if (mem_ack) begin
                        pc      <= pc_inc;
                        ins.len <= ins.len + 3'd1;
                        unique case (state)
                            FS_FETCH_OP: begin
                                ins.opcode <= mem_data;
                                ins.opext  <= '0;
                                ins.imm    <= '0;
                                ins.pc     <= pc;
                                ins.len    <= 3'd1;
                                ext_done   <= 1'b0;
                                req_q      <= 1'b0;
                                state      <= FS_DISPATCH;
                            end
                            FS_FETCH_EXT: begin
                                ins.opext <= mem_data;
                                ext_done  <= 1'b1;
                                req_q     <= 1'b0;
                                state     <= FS_DISPATCH;
                            end
                            FS_FETCH_IMM_LO: begin
                                ins.imm <= {8'h00, mem_data};
                                if (dec_imm_size == IMM_SIZE_8) begin
                                    req_q   <= VALID_REQ;
                                    valid_q <= 1'b1;
                                    state   <= FS_VALID;
                                end else begin
                                    state <= FS_FETCH_IMM_HI;
                                end
                            end
                            default: begin
                                ins.imm[15:8] <= mem_data;
                                req_q         <= VALID_REQ;
                                valid_q       <= 1'b1;
                                state         <= FS_VALID;
                            end
                        endcase
                    end else if (redirect) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= redirect_pc;
                    end
                end

                FS_DISPATCH: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        req_q <= 1'b1;
                        state <= FS_FETCH_OP;
                    end else if (dec_need_opext && !ext_done) begin
                        req_q <= 1'b1;
                        state <= FS_FETCH_EXT;
                    end else if (dec_need_imm) begin
                        req_q <= 1'b1;
                        state <= FS_FETCH_IMM_LO;
                    end else begin
                        req_q   <= VALID_REQ;
                        valid_q <= 1'b1;
                        state   <= FS_VALID;
                    end
                end

                FS_VALID: begin
`ifdef FETCH_PREFETCH_EN
                    if (redirect) begin
                        valid_q  <= 1'b0;
                        pf_valid <= 1'b0;
                        req_q    <= 1'b1;
                        state    <= FS_FETCH_OP;
                        if (outstanding) begin
                            redir_pend <= 1'b1;
                            redir_pc   <= redirect_pc;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (pf_valid || (req_q && mem_ack)) begin
                            ins.opcode <= pf_valid ? pf_buf : mem_data;
                            ins.pc     <= pf_valid ? pc - 16'd1 : pc;
                            ins.opext  <= '0;
                            ins.imm    <= '0;
                            ins.len    <= 3'd1;
                            ext_done   <= 1'b0;
                            pf_valid   <= 1'b0;
                            req_q      <= 1'b0;
                            state      <= FS_DISPATCH;
                            if (!pf_valid) pc <= pc_inc;
                        end else begin
                            state <= FS_FETCH_OP;
                        end
                    end else if (req_q && mem_ack) begin
                        pf_buf   <= mem_data;
                        pf_valid <= 1'b1;
                        pc       <= pc_inc;
                        req_q    <= 1'b0;
                    end
`else
                    if (redirect) begin
                        pc      <= redirect_pc;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= FS_FETCH_OP;
                    end else if (instr_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= FS_FETCH_OP;
                    end
`endif
                end

                default: state <= FS_IDLE;
            endcase
        end
    end

    assign mem_req      = req_q;
    assign mem_addr     = ADDR_WIDTH'(pc);
    assign dec_opcode   = ins.opcode;
    assign dec_opext    = ins.opext;
    assign instr_valid  = valid_q;
    assign instr_opcode = ins.opcode;
    assign instr_opext  = ins.opext;
    assign instr_imm    = ins.imm;
    assign instr_pc     = ins.pc;
    assign instr_len    = ins.len;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte memory with programmable wait
// states, small decoder model, vector table plus corner-case sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  dec_opcode;
    logic [7:0]  dec_opext;
    logic        dec_need_opext;
    logic        dec_need_imm;
    logic        dec_imm_size;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_opext;
    logic [15:0] instr_imm;
    logic [15:0] instr_pc;
    logic [2:0]  instr_len;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_WIDTH(24)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .dec_opcode     (dec_opcode),
        .dec_opext      (dec_opext),
        .dec_need_opext (dec_need_opext),
        .dec_need_imm   (dec_need_imm),
        .dec_imm_size   (dec_imm_size),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_opext    (instr_opext),
        .instr_imm      (instr_imm),
        .instr_pc       (instr_pc),
        .instr_len      (instr_len)
    );

    always_comb begin
        dec_need_opext = (dec_opcode == 8'hCE);
        dec_need_imm   = (dec_opcode == 8'hB0) ||
                         (dec_opcode == 8'hCE && dec_opext == 8'h44);
        dec_imm_size   = (dec_opcode == 8'hCE && dec_opext == 8'h44);
    end

    logic [7:0] mem [0:65535];
    int wait_cycles = 0;
    int wcnt = 0;

    // Ack after wait_cycles idle cycles of a held request.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= wait_cycles) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr[15:0]];
                wcnt     = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 8'h00;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [15:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        step();
        redirect    = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int k;
        k = 0;
        while (!instr_valid && k < limit) begin
            step();
            k++;
        end
        chk({name, " valid"}, 32'(instr_valid), 1);
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [31:0] bytes;
        int          wt;
        logic [7:0]  op;
        logic [7:0]  ext;
        logic [15:0] imm;
        logic [2:0]  len;
        logic [15:0] nxt;
    } vec_t;

    vec_t vt [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic        seen;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vt[0] = '{16'h1800, 32'h0000_0000, 1, 8'h00, 8'h00, 16'h0000, 3'd1, 16'h1801};
        vt[1] = '{16'h2000, 32'h1234_44CE, 0, 8'hCE, 8'h44, 16'h1234, 3'd4, 16'h2004};
        vt[2] = '{16'hFFFF, 32'h0000_7FB0, 0, 8'hB0, 8'h00, 16'h007F, 3'd2, 16'h0001};
        vt[3] = '{16'h4000, 32'h0000_10CE, 2, 8'hCE, 8'h10, 16'h0000, 3'd2, 16'h4002};
        vt[4] = '{16'h5000, 32'h0000_ABB0, 1, 8'hB0, 8'h00, 16'h00AB, 3'd2, 16'h5002};

        // Reset state and IDLE hold.
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst valid", 32'(instr_valid), 0);
        chk("rst len", 32'(instr_len), 0);
        chk("rst pc", 32'(instr_pc), 0);
        chk("rst dec_op", 32'(dec_opcode), 0);
        step();
        step();
        step();
        chk("idle hold", 32'(mem_req), 0);

        // Minimum latency: FETCH_OP, DISPATCH, then valid on the 3rd cycle.
        redir(16'h1000);
        chk("lat c1 req", 32'(mem_req), 1);
        chk("lat c1 addr", 32'(mem_addr), 32'h1000);
        chk("lat c1 valid", 32'(instr_valid), 0);
        step();
        chk("lat c2 valid", 32'(instr_valid), 0);
        chk("lat c2 req", 32'(mem_req), 0);
        step();
        chk("lat c3 valid", 32'(instr_valid), 1);
        chk("lat op", 32'(instr_opcode), 0);
        chk("lat len", 32'(instr_len), 1);
        chk("lat pc", 32'(instr_pc), 32'h1000);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = vt[i].pc + 16'(j);
                mem[a] = vt[i].bytes[8*j +: 8];
            end
            wait_cycles = vt[i].wt;
            redir(vt[i].pc);
            wait_valid($sformatf("vec%0d", i), 40);
            chk($sformatf("vec%0d op", i), 32'(instr_opcode), 32'(vt[i].op));
            chk($sformatf("vec%0d ext", i), 32'(instr_opext), 32'(vt[i].ext));
            chk($sformatf("vec%0d imm", i), 32'(instr_imm), 32'(vt[i].imm));
            chk($sformatf("vec%0d pc", i), 32'(instr_pc), 32'(vt[i].pc));
            chk($sformatf("vec%0d len", i), 32'(instr_len), 32'(vt[i].len));
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
`ifndef FETCH_PREFETCH_EN
            chk($sformatf("vec%0d next req", i), 32'(mem_req), 1);
            chk($sformatf("vec%0d next addr", i), 32'(mem_addr), 32'(vt[i].nxt));
`endif
        end

        // Redirects while the opext read to 0x2001 waits three cycles.
        wait_cycles = 0;
        mem[16'h3000] = 8'h00;
        redir(16'h2000);
        for (int k = 0; k < 20 && !(mem_req && mem_addr == 24'h002001); k++)
            step();
        chk("rd find 2001", 32'(mem_addr), 32'h2001);
        wait_cycles = 3;
        redirect    = 1'b1;
        redirect_pc = 16'h3800;
        step();
        chk("rd w1 addr", 32'(mem_addr), 32'h2001);
        chk("rd w1 req", 32'(mem_req), 1);
        redirect_pc = 16'h3000;
        step();
        redirect = 1'b0;
        chk("rd w2 addr", 32'(mem_addr), 32'h2001);
        step();
        chk("rd w3 addr", 32'(mem_addr), 32'h2001);
        step();
        wait_cycles = 0;
        chk("rd tgt addr", 32'(mem_addr), 32'h3000);
        chk("rd tgt req", 32'(mem_req), 1);
        chk("rd discard", 32'(dec_opext), 0);
        wait_valid("rd", 20);
        chk("rd pc", 32'(instr_pc), 32'h3000);
        chk("rd len", 32'(instr_len), 1);

        // Stall: outputs hold, then redirect beats a same-cycle accept.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall valid", 32'(instr_valid), 1);
            chk("stall pc", 32'(instr_pc), 32'h3000);
            chk("stall len", 32'(instr_len), 1);
`ifndef FETCH_PREFETCH_EN
            chk("stall req", 32'(mem_req), 0);
`endif
        end
        mem[16'h3200] = 8'hB0;
        mem[16'h3201] = 8'h99;
        redirect      = 1'b1;
        redirect_pc   = 16'h3200;
        instr_ready   = 1'b1;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("racc valid", 32'(instr_valid), 0);
        chk("racc addr", 32'(mem_addr), 32'h3200);
        chk("racc req", 32'(mem_req), 1);
        wait_valid("racc", 20);
        chk("racc pc", 32'(instr_pc), 32'h3200);
        chk("racc imm", 32'(instr_imm), 32'h0099);

`ifdef FETCH_PREFETCH_EN
        mem[16'h6000] = 8'h00;
        mem[16'h6001] = 8'hB0;
        mem[16'h6002] = 8'h55;
        mem[16'h6003] = 8'hCE;
        mem[16'h6100] = 8'h00;
        redir(16'h6000);
        wait_valid("pf", 20);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (mem_req && mem_addr == 24'h006001) seen = 1'b1;
            step();
        end
        chk("pf issued", 32'(seen), 1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("pf disp valid", 32'(instr_valid), 0);
        chk("pf disp req", 32'(mem_req), 0);
        chk("pf disp op", 32'(dec_opcode), 32'hB0);
        step();
        chk("pf imm addr", 32'(mem_addr), 32'h6002);
        wait_valid("pf b0", 20);
        chk("pf imm", 32'(instr_imm), 32'h0055);
        chk("pf pc", 32'(instr_pc), 32'h6001);
        chk("pf len", 32'(instr_len), 2);
        step();
        step();
        redir(16'h6100);
        wait_valid("pf rd", 20);
        chk("pf rd op", 32'(instr_opcode), 0);
        chk("pf rd pc", 32'(instr_pc), 32'h6100);
`endif

        // Reset abandons an outstanding request.
        wait_cycles = 5;
        redir(16'h7000);
        chk("mid req", 32'(mem_req), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid rst req", 32'(mem_req), 0);
        chk("mid rst valid", 32'(instr_valid), 0);
        chk("mid rst addr", 32'(mem_addr), 0);
        step();
        chk("mid idle", 32'(mem_req), 0);
        wait_cycles = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
